// File: rtl/ad_pkg.sv
// ad_pkg: shared constants for the ADC receive path.
//   ADC_DATA_W       default ADC sample width
//   DEF_DIV_1/2      default clk-per-ad_clk divide ratios (fast / slow)
//   ST_*             capture FSM state encoding
package ad_pkg;

    localparam int unsigned ADC_DATA_W = 8;
    localparam int unsigned DEF_DIV_1  = 4;
    localparam int unsigned DEF_DIV_2  = 50;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DRAIN   = 2'd3;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered head (first-word fall-through).
//   clk, rst        clock, synchronous active-high reset
//   wr_en, wr_data  push; ignored while full (even if a pop happens the same cycle)
//   rd_en           pop; ignored while empty
//   rd_data         registered head entry
//   rd_valid        registered, high while non-empty
//   full, empty     registered occupancy flags
// DEPTH must be a power of two, >= 2.
module sync_fifo #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Next read pointer and occupancy
    always_comb begin
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count;
        if (do_rd) begin
            rd_ptr_nxt = rd_ptr + AW'(1);
        end
        if (do_wr && !do_rd) begin
            count_nxt = count + CW'(1);
        end else if (!do_wr && do_rd) begin
            count_nxt = count - CW'(1);
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, flags and head register
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr   <= rd_ptr_nxt;
            count    <= count_nxt;
            full     <= (count_nxt == CW'(DEPTH));
            empty    <= (count_nxt == '0);
            rd_valid <= (count_nxt != '0);
            // Bypass the array when the incoming word becomes the new head
            rd_data  <= (do_wr && (wr_ptr == rd_ptr_nxt)) ? wr_data : mem[rd_ptr_nxt];
        end
    end

endmodule

// File: rtl/ad_sample_capture.sv
// ad_sample_capture: generates the ADC sample clock, captures ADC data once per
// sample period, frames it into fixed-length bursts and streams it out.
//   clk, rst           system clock, synchronous active-high reset
//   sel                rate select (1: DIV_1, 0: DIV_2), latched at period end
//   start              one-cycle pulse starting a frame (ignored while busy)
//   ad_data            parallel ADC output
//   ad_clk             generated ADC clock (registered)
//   m_data/m_last      stream payload at FIFO head; m_last marks frame end
//   m_valid/m_ready    stream handshake
//   busy               capture FSM not idle
//   overflow           sticky: a sample was dropped on a full FIFO
module ad_sample_capture
    import ad_pkg::*;
#(
    parameter int unsigned DATA_W     = ADC_DATA_W,
    parameter int unsigned DIV_1      = DEF_DIV_1,
    parameter int unsigned DIV_2      = DEF_DIV_2,
    parameter int unsigned PIPE_DLY   = 3,
    parameter int unsigned FRAME_LEN  = 256,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              start,
    input  logic [DATA_W-1:0] ad_data,
    output logic              ad_clk,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              overflow
);

    localparam int unsigned DIV_MAX = (DIV_1 > DIV_2) ? DIV_1 : DIV_2;
    localparam int unsigned DW      = $clog2(DIV_MAX);
    localparam int unsigned SKW     = $clog2(PIPE_DLY + 2);
    localparam int unsigned SCW     = $clog2(FRAME_LEN + 1);

    logic [DW-1:0]     div_cnt;
    logic              sel_q;
    logic              div_last;
    logic              clk_hi;
    logic [DATA_W-1:0] cap_data;
    logic              cap_vld;
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [SKW-1:0]    skip_cnt;
    logic [SKW-1:0]    skip_nxt;
    logic [SCW-1:0]    samp_cnt;
    logic [SCW-1:0]    samp_nxt;
    logic              ovf_nxt;
    logic              wr_req;
    logic              wr_last;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_head;

    // Active-ratio decode; sel_q only changes at a period boundary
    always_comb begin
        div_last = 1'b0;
        clk_hi   = 1'b0;
        if (sel_q) begin
            div_last = (div_cnt == DW'(DIV_1 - 1));
            clk_hi   = (div_cnt <  DW'(DIV_1 / 2));
        end else begin
            div_last = (div_cnt == DW'(DIV_2 - 1));
            clk_hi   = (div_cnt <  DW'(DIV_2 / 2));
        end
    end

    // Free-running divider and sample capture; the ADC is clocked in every state
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            sel_q    <= sel;
            ad_clk   <= 1'b0;
            cap_vld  <= 1'b0;
            cap_data <= '0;
        end else begin
            ad_clk  <= clk_hi;
            cap_vld <= div_last;
            if (div_last) begin
                div_cnt  <= '0;
                sel_q    <= sel;
                cap_data <= ad_data;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    // Capture FSM next-state; cap_vld is the sample strobe delayed to the capture register
    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        samp_nxt  = samp_cnt;
        ovf_nxt   = overflow;
        wr_req    = 1'b0;
        wr_last   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    ovf_nxt   = 1'b0;
                    skip_nxt  = SKW'(PIPE_DLY);
                    samp_nxt  = '0;
                    state_nxt = (PIPE_DLY == 0) ? ST_CAPTURE : ST_ARM;
                end
            end
            ST_ARM: begin
                if (cap_vld) begin
                    skip_nxt = skip_cnt - SKW'(1);
                    if (skip_cnt == SKW'(1)) begin
                        state_nxt = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (cap_vld) begin
                    wr_req   = 1'b1;
                    wr_last  = (samp_cnt == SCW'(FRAME_LEN - 1));
                    samp_nxt = samp_cnt + SCW'(1);
                    // A dropped sample still counts so the frame length is fixed in time
                    if (fifo_full) begin
                        ovf_nxt = 1'b1;
                    end
                    if (wr_last) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_empty) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
            samp_cnt <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
            samp_cnt <= samp_nxt;
            overflow <= ovf_nxt;
            busy     <= (state_nxt != ST_IDLE);
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_req),
        .wr_data  ({wr_last, cap_data}),
        .rd_en    (m_ready),
        .rd_data  (fifo_head),
        .rd_valid (m_valid),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign m_data = fifo_head[DATA_W-1:0];
    assign m_last = fifo_head[DATA_W];

endmodule

// File: tb/tb_ad_sample_capture.sv
module tb_ad_sample_capture;

    localparam int unsigned DATA_W     = 8;
    localparam int unsigned DIV_1      = 4;
    localparam int unsigned DIV_2      = 50;
    localparam int unsigned PIPE_DLY   = 3;
    localparam int unsigned FRAME_LEN  = 32;
    localparam int unsigned FIFO_DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              sel;
    logic              start;
    logic [DATA_W-1:0] ad_data;
    logic              ad_clk;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              busy;
    logic              overflow;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W:0]   got [$];
    bit                rnd_ready;
    bit                ready_lvl;
    logic              prev_clk;
    logic              rose;
    logic              stall;
    logic [DATA_W-1:0] stall_data;
    logic              stall_last;

    always #5 clk = ~clk;

    ad_sample_capture #(
        .DATA_W     (DATA_W),
        .DIV_1      (DIV_1),
        .DIV_2      (DIV_2),
        .PIPE_DLY   (PIPE_DLY),
        .FRAME_LEN  (FRAME_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .start    (start),
        .ad_data  (ad_data),
        .ad_clk   (ad_clk),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_last   (m_last),
        .busy     (busy),
        .overflow (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: record handshakes, check stall stability, ramp ad_data on ad_clk rise
    task automatic tick();
        bit              hs;
        logic [DATA_W:0] hv;
        hs         = m_valid && m_ready && !rst;
        hv         = {m_last, m_data};
        stall      = m_valid && !m_ready && !rst;
        stall_data = m_data;
        stall_last = m_last;
        @(posedge clk);
        #1;
        if (hs) got.push_back(hv);
        if (stall) chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, stall_last, stall_data});
        rose = ad_clk && !prev_clk;
        if (rose) ad_data = ad_data + DATA_W'(1);
        prev_clk = ad_clk;
        m_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : ready_lvl;
    endtask

    task automatic wait_rise();
        int g = 0;
        rose = 1'b0;
        while (!rose && g < 400) begin
            tick();
            g++;
        end
        chk("rise_timeout", rose, 1);
    endtask

    // Called right after a rise: returns high and low run lengths in clk cycles
    task automatic measure(output int hi, output int lo);
        hi = 1;
        for (int g = 0; g < 200; g++) begin
            tick();
            if (!ad_clk) break;
            hi++;
        end
        lo = 1;
        for (int g = 0; g < 200; g++) begin
            tick();
            if (ad_clk) break;
            lo++;
        end
    endtask

    // Ramp value present at start is v; first PIPE_DLY periods are discarded
    task automatic check_samples(input string tag, input logic [DATA_W-1:0] v,
                                 input int n_exp, input bit last_exp);
        chk({tag, "_count"}, got.size(), n_exp);
        for (int i = 0; i < got.size() && i < n_exp; i++) begin
            chk({tag, "_data"}, got[i][DATA_W-1:0], DATA_W'(int'(v) + PIPE_DLY + i));
            chk({tag, "_last"}, got[i][DATA_W], (last_exp && i == n_exp - 1));
        end
    endtask

    task automatic run_frame(input string tag);
        logic [DATA_W-1:0] v;
        int g;
        wait_rise();
        v = ad_data;
        got.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_on"}, busy, 1);
        g = 0;
        while (busy && g < 5000) begin
            tick();
            g++;
        end
        chk({tag, "_busy_off"}, busy, 0);
        chk({tag, "_valid_off"}, m_valid, 0);
        check_samples(tag, v, FRAME_LEN, 1'b1);
    endtask

    initial begin
        int hi, lo, g;
        logic [DATA_W-1:0] v;
        rst = 1'b1; sel = 1'b1; start = 1'b0; ad_data = '0; m_ready = 1'b0;
        ready_lvl = 1'b0; rnd_ready = 1'b0; prev_clk = 1'b0; rose = 1'b0; stall = 1'b0;
        repeat (3) tick();
        chk("rst_ad_clk", ad_clk, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;

        // Idle clocking at the fast ratio
        wait_rise();
        for (int k = 0; k < 2; k++) begin
            measure(hi, lo);
            chk("idle_hi", hi, DIV_1 / 2);
            chk("idle_lo", lo, DIV_1 / 2);
        end
        chk("idle_valid", m_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_ovf", overflow, 0);

        // Full frame, always ready
        ready_lvl = 1'b1;
        run_frame("ramp");
        chk("ramp_ovf", overflow, 0);

        // Rate switch during the high phase: old period completes, then slow period
        wait_rise();
        tick();
        sel = 1'b0;
        g = 0;
        while (ad_clk && g < 200) begin tick(); g++; end
        lo = 1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (ad_clk) break;
            lo++;
        end
        chk("sw_old_lo", lo, DIV_1 / 2);
        measure(hi, lo);
        chk("sw_new_hi", hi, DIV_2 / 2);
        chk("sw_new_lo", lo, DIV_2 / 2);

        // Random backpressure at the slow ratio
        rnd_ready = 1'b1;
        run_frame("bp");
        chk("bp_ovf", overflow, 0);
        rnd_ready = 1'b0;

        // Overflow: no ready for the whole frame
        sel = 1'b1;
        ready_lvl = 1'b0;
        m_ready = 1'b0;
        wait_rise();
        wait_rise();
        v = ad_data;
        got.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (200) tick();
        chk("ovf_flag", overflow, 1);
        chk("ovf_valid", m_valid, 1);
        chk("ovf_busy", busy, 1);
        ready_lvl = 1'b1;
        m_ready = 1'b1;
        g = 0;
        while (busy && g < 500) begin tick(); g++; end
        chk("ovf_busy_off", busy, 0);
        check_samples("ovf", v, FIFO_DEPTH, 1'b0);

        // Reset mid-frame, then a clean frame; start also clears sticky overflow
        wait_rise();
        v = ad_data;
        got.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_clr_ovf", overflow, 0);
        g = 0;
        while (got.size() < 5 && g < 1000) begin tick(); g++; end
        check_samples("pre_rst", v, 5, 1'b0);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ad_clk", ad_clk, 0);
        chk("mid_rst_data", m_data, 0);
        chk("mid_rst_last", m_last, 0);
        rst = 1'b0;
        run_frame("post_rst");
        chk("post_rst_ovf", overflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
